// File: rtl/ps2_key_sequencer_if.sv
// Keyboard FIFO link between a PS/2 receiver FIFO and the key sequencer.
// The master drives the FIFO head; the slave answers with a pop strobe.
interface ps2_key_sequencer_if;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;

    modport master (
        output ready,
        output data,
        output overflow,
        input  nextdata_n
    );

    modport slave (
        input  ready,
        input  data,
        input  overflow,
        output nextdata_n
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan byte sequencer: pops bytes from the keyboard FIFO and turns
// make/break/extended prefixes into press and release events.
module ps2_key_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 clrn,
    ps2_key_sequencer_if.slave   kbd,
    output logic                 evt_valid,
    output logic                 evt_make,
    output logic                 evt_ext,
    output logic [7:0]           evt_code,
    output logic                 key_down,
    output logic [7:0]           cur_code,
    output logic [CNT_W-1:0]     key_count,
    output logic                 ovf_err
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        GAP
    } state_t;

    state_t             state, state_n;
    logic [7:0]         byte_q, byte_n;
    logic               brk_q, brk_n;
    logic               ext_q, ext_n;
    logic               nd_n;
    logic               valid_n, make_n, eext_n;
    logic [7:0]         code_n, cur_n;
    logic               down_n, ovf_n;
    logic [CNT_W-1:0]   cnt_n;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state          <= IDLE;
            byte_q         <= 8'h00;
            brk_q          <= 1'b0;
            ext_q          <= 1'b0;
            kbd.nextdata_n <= 1'b1;
            evt_valid      <= 1'b0;
            evt_make       <= 1'b0;
            evt_ext        <= 1'b0;
            evt_code       <= 8'h00;
            key_down       <= 1'b0;
            cur_code       <= 8'h00;
            key_count      <= '0;
            ovf_err        <= 1'b0;
        end else begin
            state          <= state_n;
            byte_q         <= byte_n;
            brk_q          <= brk_n;
            ext_q          <= ext_n;
            kbd.nextdata_n <= nd_n;
            evt_valid      <= valid_n;
            evt_make       <= make_n;
            evt_ext        <= eext_n;
            evt_code       <= code_n;
            key_down       <= down_n;
            cur_code       <= cur_n;
            key_count      <= cnt_n;
            ovf_err        <= ovf_n;
        end
    end

    // The pop strobe is registered from the next state, so it is low
    // for exactly the POP cycle and never glitches.
    always_comb begin
        state_n = state;
        byte_n  = byte_q;
        brk_n   = brk_q;
        ext_n   = ext_q;
        nd_n    = 1'b1;
        valid_n = 1'b0;
        make_n  = evt_make;
        eext_n  = evt_ext;
        code_n  = evt_code;
        down_n  = key_down;
        cur_n   = cur_code;
        cnt_n   = key_count;
        ovf_n   = ovf_err | kbd.overflow;

        unique case (state)
            IDLE: begin
                if (kbd.ready) begin
                    byte_n  = kbd.data;
                    state_n = POP;
                    nd_n    = 1'b0;
                end
            end
            POP: begin
                state_n = GAP;
                if (byte_q == 8'hF0) begin
                    brk_n = 1'b1;
                end else if (byte_q == 8'hE0) begin
                    ext_n = 1'b1;
                end else if (brk_q) begin
                    valid_n = 1'b1;
                    make_n  = 1'b0;
                    eext_n  = ext_q;
                    code_n  = byte_q;
                    if (byte_q == cur_code)
                        down_n = 1'b0;
                    brk_n   = 1'b0;
                    ext_n   = 1'b0;
                end else if (key_down && byte_q == cur_code) begin
                    // typematic repeat of the held key
                    ext_n = 1'b0;
                end else begin
                    valid_n = 1'b1;
                    make_n  = 1'b1;
                    eext_n  = ext_q;
                    code_n  = byte_q;
                    down_n  = 1'b1;
                    cur_n   = byte_q;
                    cnt_n   = key_count + 1'b1;
                    ext_n   = 1'b0;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of press counter key_count.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port: clrn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ready  input  1  keyboard FIFO non-empty.
REQ-005 SHALL have port: data  input  8  scan byte at FIFO head, valid while ready=1.
REQ-006 SHALL have port: overflow  input  1  keyboard FIFO overflow indication.
REQ-007 SHALL have port: nextdata_n  output  1  active-low pop strobe to keyboard FIFO.
REQ-008 SHALL have port: evt_valid  output  1  one-cycle pulse, decoded key event.
REQ-009 SHALL have port: evt_make  output  1  1 = press, 0 = release; valid with evt_valid.
REQ-010 SHALL have port: evt_ext  output  1  event carried E0 prefix; valid with evt_valid.
REQ-011 SHALL have port: evt_code  output  8  event scan code; valid with evt_valid.
REQ-012 SHALL have port: key_down  output  1  a key is currently held.
REQ-013 SHALL have port: cur_code  output  8  code of last pressed key, held after release.
REQ-014 SHALL have port: key_count  output  CNT_W  count of new presses.
REQ-015 SHALL have port: ovf_err  output  1  sticky overflow flag.

Function
REQ-016 SHALL use FSM states IDLE, POP, GAP; one byte consumed per 3 cycles at most.
REQ-017 IDLE: if ready=1, latch data into byte register, next state POP; else stay IDLE.
REQ-018 POP: drive nextdata_n=0 for exactly this one cycle, decode latched byte, next state GAP.
REQ-019 GAP: nextdata_n=1, next state IDLE; ready SHALL NOT be sampled in GAP.
REQ-020 nextdata_n SHALL be 1 in all states except POP, registered (glitch-free).
REQ-021 Decode 0xF0: set break flag, no event.
REQ-022 Decode 0xE0: set ext flag, no event.
REQ-023 Other byte with break flag set: release event (evt_make=0, evt_code=byte, evt_ext=ext flag); clear key_down only if byte==cur_code; clear break and ext flags.
REQ-024 Other byte, break clear, key_down=1 and byte==cur_code: typematic repeat; no event, count unchanged; clear ext flag.
REQ-025 Other byte, break clear, otherwise: press event (evt_make=1); key_down=1; cur_code=byte; key_count+1; clear ext flag.
REQ-026 key_count SHALL wrap modulo 2^CNT_W (all-ones + 1 -> 0).
REQ-027 evt_valid SHALL be high exactly in the GAP cycle following the decoding POP; evt_* fields held until next event.
REQ-028 F0 F0 sequence: break flag stays set; E0 after F0 and F0 after E0 SHALL both keep both flags set.
REQ-029 ovf_err SHALL set on any cycle with overflow=1 and clear only on reset; decoding continues regardless.
REQ-030 ready dropping while in POP/GAP SHALL NOT alter the sequence; latched byte is used.

Reset
REQ-031 clrn=0 SHALL immediately force state IDLE, nextdata_n=1, evt_valid=0, evt_make=0, evt_ext=0, evt_code=0, key_down=0, cur_code=0, key_count=0, ovf_err=0, break/ext flags=0.
REQ-032 Reset asserted during POP SHALL abort the pop (nextdata_n returns to 1 asynchronously); after release, FSM starts in IDLE.

Verification
REQ-033 Bytes 1C, F0, 1C -> press evt (make=1, code 1C), key_count=1, key_down=1; then release evt (make=0, code 1C), key_down=0, cur_code=1C.
REQ-034 Bytes 1C,1C,1C,F0,1C -> one press evt, one release evt, key_count=1; nextdata_n low exactly 5 cycles, each separated by >=2 high cycles.
REQ-035 Bytes E0,75,E0,F0,75 -> press evt ext=1 code 75; release evt ext=1 code 75; key_down=0.
REQ-036 Bytes 1C, F0, 32 -> release evt code 32, key_down stays 1, cur_code=1C.
REQ-037 256 distinct alternating presses (1C, F0, 1C, 32, F0, 32 ...) with CNT_W=8 -> key_count wraps to 0; overflow pulse one cycle -> ovf_err=1 until clrn=0.
REQ-038 clrn=0 asserted during POP after byte 1C with ready held -> all outputs at reset values same cycle; after release, 1C re-read and press evt issued.
